axi_master: RTL and testbench
=============================

Name:
axi_master

Overview:
- Single-outstanding AXI4 master: the initiator for the team's AXI memory slave.
- Accepts one read or write command at a time on a simple valid/ready command port.
- Drives the AW/W/B or AR/R channels; streams write data in from and read data out to local valid/ready ports.
- Emits a one-cycle completion pulse carrying the response.

Parameters:
ID_WIDTH  4  AXI ID width
ADDR_WIDTH  32  AXI address width
DATA_WIDTH  32  data bus width, multiple of 8
LEN_WIDTH  8  AWLEN/ARLEN width; beats = len+1

Ports:
ACLK  in  1  clock, all logic on rising edge
ARESET  in  1  synchronous active-high reset
cmd_valid / cmd_ready  in / out  1  command handshake
cmd_write, cmd_id, cmd_addr, cmd_len, cmd_size, cmd_burst  in  1, ID_WIDTH, ADDR_WIDTH, LEN_WIDTH, 3, 2  command fields (1 = write)
wr_data / wr_strb  in  DATA_WIDTH / DATA_WIDTH/8  write beat source
wr_valid / wr_ready  in / out  1  write beat handshake
rd_data / rd_last  out  DATA_WIDTH / 1  read beat sink
rd_valid / rd_ready  out / in  1  read beat handshake
done, done_write, done_resp, done_id  out  1, 1, 2, ID_WIDTH  completion pulse, direction, response, ID
MEM_AWID / MEM_ARID  out  ID_WIDTH  latched cmd_id
MEM_AWADDR / MEM_ARADDR  out  ADDR_WIDTH  latched cmd_addr
MEM_AWLEN / MEM_ARLEN  out  LEN_WIDTH  latched cmd_len
MEM_AWSIZE / MEM_ARSIZE  out  3  latched cmd_size
MEM_AWBURST / MEM_ARBURST  out  2  latched cmd_burst
MEM_AWVALID / MEM_ARVALID  out  1  address valid
MEM_AWREADY / MEM_ARREADY  in  1  address ready
MEM_AxLOCK=1'b0, MEM_AxCACHE=4'b0, MEM_AxPROT=3'b0, MEM_AxQOS=4'b0  out  1/4/3/4  constant ties, both AW and AR
MEM_WDATA / MEM_WSTRB  out  DATA_WIDTH / DATA_WIDTH/8  wired from wr_data / wr_strb
MEM_WLAST  out  1  high on final beat
MEM_WVALID / MEM_WREADY  out / in  1  write data handshake
MEM_BID, MEM_BRESP, MEM_BVALID  in  ID_WIDTH, 2, 1  write response
MEM_BREADY  out  1  write response ready
MEM_RID, MEM_RDATA, MEM_RRESP, MEM_RLAST, MEM_RVALID  in  ID_WIDTH, DATA_WIDTH, 2, 1, 1  read data
MEM_RREADY  out  1  read data ready

Behaviour:
- FSM states: IDLE, CHK, AW, W, B, AR, R, DONE. ARESET sampled high forces IDLE next edge.
- Reset: all VALID/READY outputs, done, latched fields and beat counter are 0. cmd_ready = (state==IDLE), so it is 1 from the first cycle after reset release.
- IDLE: cmd_valid&&cmd_ready latches all cmd fields and moves to CHK.
- CHK (1 cycle): cmd_burst in {2'b10,2'b11} or 2^cmd_size > DATA_WIDTH/8 → DONE with resp 2'b10 and no bus activity. Otherwise → AW (write) or AR (read).
- AW/AR: VALID is registered high on state entry. Payload stays stable while VALID && !READY. On the handshake edge VALID drops, beat counter clears, and the FSM moves to W/R. The master never waits for READY before asserting VALID.
- W: MEM_WVALID = wr_valid, wr_ready = MEM_WREADY (both only in W, else 0). MEM_WLAST = (beat==latched len).
- W: each WVALID&&WREADY increments beat; the handshake at beat==len → B. len=0 gives a single beat with WLAST high.
- B: MEM_BREADY=1. On BVALID&&BREADY, capture BRESP/BID → DONE.
- R: rd_valid = MEM_RVALID, MEM_RREADY = rd_ready, rd_data = MEM_RDATA, rd_last = MEM_RLAST (all gated to state R, else 0).
- R, response tracking: the first non-OKAY RRESP is held as the response (sticky).
- R, length check: RLAST at beat!=len, or beat>len without RLAST, sets response 2'b10 unless already non-OKAY. Beats continue to be accepted until an RLAST handshake → DONE.
- DONE (1 cycle): done=1 with done_write, done_resp and done_id (captured BID/RID, or latched cmd_id on CHK reject), then → IDLE. Minimum command-to-command spacing is therefore fixed by the FSM.
- Beat counter width is LEN_WIDTH+1 so len=255 does not wrap.
- Per-beat addresses are not generated; the slave owns address increment.
- Upstream must hold wr_data/wr_strb while wr_valid && !wr_ready.
- ARESET mid-burst: the next cycle has all VALID/READY at 0, no done pulse, and the transfer is abandoned.

Test Plan:
- Write INCR, addr 0x10, size 2, len 3, data 0xA0..0xA3, id 5 → AWVALID held until AWREADY; 4 W beats with WLAST only on the 4th; done=1, done_write=1, done_resp=00, done_id=5.
- Read the same range → rd_data 0xA0,0xA1,0xA2,0xA3 with rd_last on the 4th; done_resp=00, done_write=0.
- Write len 7 with wr_valid toggling every cycle, then read with rd_ready low 3 cycles mid-burst → exactly 8 beats each way with no drop or duplicate; AW/AR payload and MEM_RREADY behave as specified.
- Read addr 0x400, slave returns RRESP=11 → done_resp=11; write addr 0x400, BRESP=11 → done_resp=11.
- cmd_burst=2'b10 → AWVALID/ARVALID never assert; done two cycles after the command handshake with done_resp=10.
- ARESET high for 1 cycle after W beat 1 of a len-3 write → next cycle MEM_WVALID=0, MEM_AWVALID=0, done=0; cmd_ready=1 the cycle after release.

Source files
------------

// File: rtl/axi_master_if.sv
// Bundle of the command, local data and AXI4 memory-side signals of the
// single-outstanding master; the master modport is the design's view.
interface axi_master_if #(
   parameter int ID_WIDTH   = 4,
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int LEN_WIDTH  = 8
);
   logic                    cmd_valid;
   logic                    cmd_ready;
   logic                    cmd_write;
   logic [ID_WIDTH-1:0]     cmd_id;
   logic [ADDR_WIDTH-1:0]   cmd_addr;
   logic [LEN_WIDTH-1:0]    cmd_len;
   logic [2:0]              cmd_size;
   logic [1:0]              cmd_burst;

   logic [DATA_WIDTH-1:0]   wr_data;
   logic [DATA_WIDTH/8-1:0] wr_strb;
   logic                    wr_valid;
   logic                    wr_ready;
   logic [DATA_WIDTH-1:0]   rd_data;
   logic                    rd_last;
   logic                    rd_valid;
   logic                    rd_ready;

   logic                    done;
   logic                    done_write;
   logic [1:0]              done_resp;
   logic [ID_WIDTH-1:0]     done_id;

   logic [ID_WIDTH-1:0]     MEM_AWID,    MEM_ARID;
   logic [ADDR_WIDTH-1:0]   MEM_AWADDR,  MEM_ARADDR;
   logic [LEN_WIDTH-1:0]    MEM_AWLEN,   MEM_ARLEN;
   logic [2:0]              MEM_AWSIZE,  MEM_ARSIZE;
   logic [1:0]              MEM_AWBURST, MEM_ARBURST;
   logic                    MEM_AWVALID, MEM_ARVALID;
   logic                    MEM_AWREADY, MEM_ARREADY;
   logic                    MEM_AWLOCK,  MEM_ARLOCK;
   logic [3:0]              MEM_AWCACHE, MEM_ARCACHE;
   logic [2:0]              MEM_AWPROT,  MEM_ARPROT;
   logic [3:0]              MEM_AWQOS,   MEM_ARQOS;

   logic [DATA_WIDTH-1:0]   MEM_WDATA;
   logic [DATA_WIDTH/8-1:0] MEM_WSTRB;
   logic                    MEM_WLAST;
   logic                    MEM_WVALID;
   logic                    MEM_WREADY;

   logic [ID_WIDTH-1:0]     MEM_BID;
   logic [1:0]              MEM_BRESP;
   logic                    MEM_BVALID;
   logic                    MEM_BREADY;

   logic [ID_WIDTH-1:0]     MEM_RID;
   logic [DATA_WIDTH-1:0]   MEM_RDATA;
   logic [1:0]              MEM_RRESP;
   logic                    MEM_RLAST;
   logic                    MEM_RVALID;
   logic                    MEM_RREADY;

   modport master (
      input  cmd_valid, cmd_write, cmd_id, cmd_addr, cmd_len, cmd_size, cmd_burst,
      output cmd_ready,
      input  wr_data, wr_strb, wr_valid, rd_ready,
      output wr_ready, rd_data, rd_last, rd_valid,
      output done, done_write, done_resp, done_id,
      output MEM_AWID, MEM_AWADDR, MEM_AWLEN, MEM_AWSIZE, MEM_AWBURST, MEM_AWVALID,
      output MEM_AWLOCK, MEM_AWCACHE, MEM_AWPROT, MEM_AWQOS,
      input  MEM_AWREADY,
      output MEM_ARID, MEM_ARADDR, MEM_ARLEN, MEM_ARSIZE, MEM_ARBURST, MEM_ARVALID,
      output MEM_ARLOCK, MEM_ARCACHE, MEM_ARPROT, MEM_ARQOS,
      input  MEM_ARREADY,
      output MEM_WDATA, MEM_WSTRB, MEM_WLAST, MEM_WVALID,
      input  MEM_WREADY,
      input  MEM_BID, MEM_BRESP, MEM_BVALID,
      output MEM_BREADY,
      input  MEM_RID, MEM_RDATA, MEM_RRESP, MEM_RLAST, MEM_RVALID,
      output MEM_RREADY
   );

   modport slave (
      output cmd_valid, cmd_write, cmd_id, cmd_addr, cmd_len, cmd_size, cmd_burst,
      input  cmd_ready,
      output wr_data, wr_strb, wr_valid, rd_ready,
      input  wr_ready, rd_data, rd_last, rd_valid,
      input  done, done_write, done_resp, done_id,
      input  MEM_AWID, MEM_AWADDR, MEM_AWLEN, MEM_AWSIZE, MEM_AWBURST, MEM_AWVALID,
      input  MEM_AWLOCK, MEM_AWCACHE, MEM_AWPROT, MEM_AWQOS,
      output MEM_AWREADY,
      input  MEM_ARID, MEM_ARADDR, MEM_ARLEN, MEM_ARSIZE, MEM_ARBURST, MEM_ARVALID,
      input  MEM_ARLOCK, MEM_ARCACHE, MEM_ARPROT, MEM_ARQOS,
      output MEM_ARREADY,
      input  MEM_WDATA, MEM_WSTRB, MEM_WLAST, MEM_WVALID,
      output MEM_WREADY,
      output MEM_BID, MEM_BRESP, MEM_BVALID,
      input  MEM_BREADY,
      output MEM_RID, MEM_RDATA, MEM_RRESP, MEM_RLAST, MEM_RVALID,
      input  MEM_RREADY
   );
endinterface

// File: rtl/axi_master.sv
// Single-outstanding AXI4 master: takes one command, runs the AW/W/B or
// AR/R sequence for it and reports completion with a one-cycle done pulse.
module axi_master #(
   parameter int ID_WIDTH   = 4,
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int LEN_WIDTH  = 8
) (
   input logic          ACLK,
   input logic          ARESET,
   axi_master_if.master bus
);
   localparam int         STRB_WIDTH  = DATA_WIDTH / 8;
   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic [2:0] {IDLE, CHK, AW, W, B, AR, R, DONE} state_t;

   state_t                state;
   state_t                next_state;
   logic                  lat_write;
   logic [ID_WIDTH-1:0]   lat_id;
   logic [ADDR_WIDTH-1:0] lat_addr;
   logic [LEN_WIDTH-1:0]  lat_len;
   logic [2:0]            lat_size;
   logic [1:0]            lat_burst;
   logic [LEN_WIDTH:0]    beat;
   logic [1:0]            resp;
   logic [ID_WIDTH-1:0]   resp_id;

   logic bad_cmd;
   logic last_beat;
   logic w_hs;
   logic r_hs;
   logic len_err;

   // WRAP/reserved bursts and beats wider than the bus are refused up front
   always_comb begin
      bad_cmd   = lat_burst[1] || ((32'd1 << lat_size) > 32'(STRB_WIDTH));
      last_beat = (beat == {1'b0, lat_len});
      w_hs      = (state == W) && bus.wr_valid && bus.MEM_WREADY;
      r_hs      = (state == R) && bus.MEM_RVALID && bus.rd_ready;
      len_err   = (bus.MEM_RLAST && !last_beat) ||
                  ((beat > {1'b0, lat_len}) && !bus.MEM_RLAST);
   end

   always_ff @(posedge ACLK) begin
      if (ARESET) state <= IDLE;
      else        state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE: if (bus.cmd_valid) next_state = CHK;
         CHK: begin
            if (bad_cmd)        next_state = DONE;
            else if (lat_write) next_state = AW;
            else                next_state = AR;
         end
         AW:   if (bus.MEM_AWREADY) next_state = W;
         W:    if (w_hs && last_beat) next_state = B;
         B:    if (bus.MEM_BVALID) next_state = DONE;
         AR:   if (bus.MEM_ARREADY) next_state = R;
         R:    if (r_hs && bus.MEM_RLAST) next_state = DONE;
         DONE: next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         lat_write <= 1'b0;
         lat_id    <= '0;
         lat_addr  <= '0;
         lat_len   <= '0;
         lat_size  <= '0;
         lat_burst <= '0;
         beat      <= '0;
         resp      <= RESP_OKAY;
         resp_id   <= '0;
      end else begin
         case (state)
            IDLE: if (bus.cmd_valid) begin
               lat_write <= bus.cmd_write;
               lat_id    <= bus.cmd_id;
               lat_addr  <= bus.cmd_addr;
               lat_len   <= bus.cmd_len;
               lat_size  <= bus.cmd_size;
               lat_burst <= bus.cmd_burst;
            end
            CHK: begin
               resp    <= bad_cmd ? RESP_SLVERR : RESP_OKAY;
               resp_id <= lat_id;
            end
            AW: if (bus.MEM_AWREADY) beat <= '0;
            AR: if (bus.MEM_ARREADY) beat <= '0;
            W:  if (w_hs) beat <= beat + 1'b1;
            B: if (bus.MEM_BVALID) begin
               resp    <= bus.MEM_BRESP;
               resp_id <= bus.MEM_BID;
            end
            // first error wins; a bad beat count only reports if nothing else did
            R: if (r_hs) begin
               if (resp == RESP_OKAY) begin
                  if (bus.MEM_RRESP != RESP_OKAY) resp <= bus.MEM_RRESP;
                  else if (len_err)               resp <= RESP_SLVERR;
               end
               if (beat != '1)    beat    <= beat + 1'b1;
               if (bus.MEM_RLAST) resp_id <= bus.MEM_RID;
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      bus.cmd_ready   = (state == IDLE);

      bus.MEM_AWID    = lat_id;
      bus.MEM_AWADDR  = lat_addr;
      bus.MEM_AWLEN   = lat_len;
      bus.MEM_AWSIZE  = lat_size;
      bus.MEM_AWBURST = lat_burst;
      bus.MEM_AWVALID = (state == AW);
      bus.MEM_AWLOCK  = 1'b0;
      bus.MEM_AWCACHE = 4'b0;
      bus.MEM_AWPROT  = 3'b0;
      bus.MEM_AWQOS   = 4'b0;

      bus.MEM_ARID    = lat_id;
      bus.MEM_ARADDR  = lat_addr;
      bus.MEM_ARLEN   = lat_len;
      bus.MEM_ARSIZE  = lat_size;
      bus.MEM_ARBURST = lat_burst;
      bus.MEM_ARVALID = (state == AR);
      bus.MEM_ARLOCK  = 1'b0;
      bus.MEM_ARCACHE = 4'b0;
      bus.MEM_ARPROT  = 3'b0;
      bus.MEM_ARQOS   = 4'b0;

      bus.MEM_WDATA   = bus.wr_data;
      bus.MEM_WSTRB   = bus.wr_strb;
      bus.MEM_WVALID  = (state == W) && bus.wr_valid;
      bus.MEM_WLAST   = (state == W) && last_beat;
      bus.wr_ready    = (state == W) && bus.MEM_WREADY;

      bus.MEM_BREADY  = (state == B);

      bus.MEM_RREADY  = (state == R) && bus.rd_ready;
      bus.rd_valid    = (state == R) && bus.MEM_RVALID;
      bus.rd_last     = (state == R) && bus.MEM_RLAST;
      bus.rd_data     = (state == R) ? bus.MEM_RDATA : '0;

      bus.done        = (state == DONE);
      bus.done_write  = (state == DONE) && lat_write;
      bus.done_resp   = (state == DONE) ? resp : RESP_OKAY;
      bus.done_id     = (state == DONE) ? resp_id : '0;
   end
endmodule

// File: tb/tb_axi_master.sv
// Directed bench for axi_master: a small AXI memory slave, a write-data
// feeder and a read sink surround the DUT; each scenario checks its results.
module tb_axi_master;
   localparam int ID_WIDTH   = 4;
   localparam int ADDR_WIDTH = 32;
   localparam int DATA_WIDTH = 32;
   localparam int LEN_WIDTH  = 8;

   logic ACLK = 1'b0;
   logic ARESET;
   int   tests = 0;
   int   fails = 0;
   int   cyc   = 0;

   axi_master_if #(.ID_WIDTH(ID_WIDTH), .ADDR_WIDTH(ADDR_WIDTH),
                   .DATA_WIDTH(DATA_WIDTH), .LEN_WIDTH(LEN_WIDTH)) bus ();

   axi_master #(.ID_WIDTH(ID_WIDTH), .ADDR_WIDTH(ADDR_WIDTH),
                .DATA_WIDTH(DATA_WIDTH), .LEN_WIDTH(LEN_WIDTH)) dut (
      .ACLK   (ACLK),
      .ARESET (ARESET),
      .bus    (bus.master)
   );

   always #5 ACLK = ~ACLK;
   always @(posedge ACLK) cyc <= cyc + 1;

   logic [31:0] mem [0:255];
   int          aw_delay = 0, ar_delay = 0, aw_cnt = 0, ar_cnt = 0;
   logic [31:0] aw_addr_q = '0, ar_addr_q = '0;
   logic [7:0]  aw_len_q = '0, ar_len_q = '0;
   logic [3:0]  aw_id_q = '0, ar_id_q = '0;
   int          w_idx = 0, r_beat = 0;
   bit          r_active = 0, b_pend = 0;
   logic [31:0] wsrc [0:15];
   int          wn = 0, wi = 0;
   bit          wr_toggle = 0, tog = 0, rd_stall_en = 0;
   int          stall_cnt = 0;

   logic [31:0] wq_data [$];
   bit          wq_last [$];
   logic [31:0] rq_data [$];
   bit          rq_last [$];
   int          done_cnt = 0, done_cyc = 0, hs_cyc = 0;
   bit          done_w = 0;
   logic [1:0]  done_r = '0;
   logic [3:0]  done_i = '0;
   int          aw_hi = 0, ar_hi = 0, rstall = 0;
   bit          aw_moved = 0, aw_prev_wait = 0;
   logic [31:0] aw_prev_addr = '0;

   function automatic logic [7:0] widx(input logic [31:0] a, input int b);
      return 8'((a >> 2) + 32'(b));
   endfunction

   // Handshakes are observed on the falling edge; responses change just after the rising edge
   initial begin : slave_model
      for (int i = 0; i < 256; i++) mem[i] = '0;
      bus.MEM_AWREADY = 0; bus.MEM_ARREADY = 0; bus.MEM_WREADY = 0;
      bus.MEM_BVALID = 0; bus.MEM_BID = '0; bus.MEM_BRESP = '0;
      bus.MEM_RVALID = 0; bus.MEM_RID = '0; bus.MEM_RDATA = '0;
      bus.MEM_RRESP = '0; bus.MEM_RLAST = 0;
      bus.wr_valid = 0; bus.wr_data = '0; bus.wr_strb = 4'hF; bus.rd_ready = 1;
      forever begin
         @(negedge ACLK);
         if (bus.MEM_AWVALID) begin
            aw_hi++;
            if (aw_prev_wait && bus.MEM_AWADDR !== aw_prev_addr) aw_moved = 1;
         end
         aw_prev_wait = bus.MEM_AWVALID && !bus.MEM_AWREADY;
         aw_prev_addr = bus.MEM_AWADDR;
         if (bus.MEM_ARVALID) ar_hi++;
         if (bus.MEM_RVALID && !bus.MEM_RREADY) rstall++;
         if (bus.done) begin
            done_cnt++; done_cyc = cyc;
            done_w = bus.done_write; done_r = bus.done_resp; done_i = bus.done_id;
         end
         if (bus.rd_valid && bus.rd_ready) begin
            rq_data.push_back(bus.rd_data); rq_last.push_back(bus.rd_last);
         end
         if (bus.wr_valid && bus.wr_ready) wi++;
         if (bus.MEM_AWVALID && bus.MEM_AWREADY) begin
            aw_addr_q = bus.MEM_AWADDR; aw_len_q = bus.MEM_AWLEN; aw_id_q = bus.MEM_AWID;
            aw_cnt = 0; w_idx = 0;
         end else if (bus.MEM_AWVALID) aw_cnt++;
         if (bus.MEM_ARVALID && bus.MEM_ARREADY) begin
            ar_addr_q = bus.MEM_ARADDR; ar_len_q = bus.MEM_ARLEN; ar_id_q = bus.MEM_ARID;
            ar_cnt = 0; r_beat = 0; r_active = 1;
         end else if (bus.MEM_ARVALID) ar_cnt++;
         if (bus.MEM_WVALID && bus.MEM_WREADY) begin
            mem[widx(aw_addr_q, w_idx)] = bus.MEM_WDATA;
            wq_data.push_back(bus.MEM_WDATA); wq_last.push_back(bus.MEM_WLAST);
            w_idx++;
            if (bus.MEM_WLAST) b_pend = 1;
         end
         if (bus.MEM_BVALID && bus.MEM_BREADY) b_pend = 0;
         if (bus.MEM_RVALID && bus.MEM_RREADY) begin
            if (bus.MEM_RLAST) r_active = 0;
            r_beat++;
         end

         @(posedge ACLK); #1;
         bus.MEM_AWREADY = bus.MEM_AWVALID && (aw_cnt >= aw_delay);
         bus.MEM_ARREADY = bus.MEM_ARVALID && (ar_cnt >= ar_delay);
         bus.MEM_WREADY  = 1;
         bus.MEM_BVALID  = b_pend;
         bus.MEM_BID     = aw_id_q;
         bus.MEM_BRESP   = (aw_addr_q == 32'h400) ? 2'b11 : 2'b00;
         bus.MEM_RVALID  = r_active;
         bus.MEM_RDATA   = mem[widx(ar_addr_q, r_beat)];
         bus.MEM_RLAST   = r_active && (r_beat == int'(ar_len_q));
         bus.MEM_RID     = ar_id_q;
         bus.MEM_RRESP   = (ar_addr_q == 32'h400) ? 2'b11 : 2'b00;
         if (wi < wn) begin
            tog = !tog;
            bus.wr_valid = wr_toggle ? tog : 1'b1;
            bus.wr_data  = wsrc[wi];
         end else begin
            bus.wr_valid = 0;
         end
         if (rd_stall_en && rq_data.size() == 2 && stall_cnt < 3) begin
            bus.rd_ready = 0; stall_cnt++;
         end else begin
            bus.rd_ready = 1;
         end
      end
   end

   task automatic clear_mon;
      wq_data.delete(); wq_last.delete(); rq_data.delete(); rq_last.delete();
      done_cnt = 0; aw_hi = 0; ar_hi = 0; rstall = 0; aw_moved = 0; stall_cnt = 0;
   endtask

   task automatic issue(input bit w, input logic [3:0] id, input logic [31:0] addr,
                        input logic [7:0] len, input logic [2:0] size, input logic [1:0] burst);
      bit got = 0;
      @(posedge ACLK); #1;
      bus.cmd_valid = 1; bus.cmd_write = w; bus.cmd_id = id; bus.cmd_addr = addr;
      bus.cmd_len = len; bus.cmd_size = size; bus.cmd_burst = burst;
      for (int i = 0; i < 20; i++) begin
         @(negedge ACLK);
         if (bus.cmd_ready) begin got = 1; hs_cyc = cyc; break; end
      end
      @(posedge ACLK); #1;
      bus.cmd_valid = 0;
      if (!got) begin
         tests++; fails++;
         $display("[TB] FAIL cmd_handshake: cmd_ready got 0 for 20 cycles, required 1");
      end
   endtask

   task automatic wait_done(input string name);
      int n = 0;
      while (done_cnt == 0 && n < 300) begin @(posedge ACLK); n++; end
      if (done_cnt == 0) begin
         tests++; fails++;
         $display("[TB] FAIL %s_timeout: done got 0 after 300 cycles, required 1", name);
      end
      repeat (2) @(posedge ACLK);
   endtask

   task automatic test_reset;
      ARESET = 1;
      repeat (3) @(posedge ACLK);
      #1 ARESET = 0;
      @(negedge ACLK);
      tests++;
      if (bus.cmd_ready !== 1'b1)
         begin fails++; $display("[TB] FAIL reset_cmd_ready: got %b required 1", bus.cmd_ready); end
      tests++;
      if ({bus.MEM_AWVALID, bus.MEM_ARVALID, bus.MEM_WVALID, bus.MEM_BREADY, bus.MEM_RREADY} !== 5'b0)
         begin fails++; $display("[TB] FAIL reset_bus_valids: got %b required 00000",
            {bus.MEM_AWVALID, bus.MEM_ARVALID, bus.MEM_WVALID, bus.MEM_BREADY, bus.MEM_RREADY}); end
      tests++;
      if ({bus.done, bus.wr_ready, bus.rd_valid, bus.MEM_WLAST} !== 4'b0)
         begin fails++; $display("[TB] FAIL reset_local: got %b required 0000",
            {bus.done, bus.wr_ready, bus.rd_valid, bus.MEM_WLAST}); end
      tests++;
      if ({bus.MEM_AWADDR, bus.MEM_ARLEN, bus.MEM_AWID} !== '0)
         begin fails++; $display("[TB] FAIL reset_fields: addr %h len %h id %h required 0",
            bus.MEM_AWADDR, bus.MEM_ARLEN, bus.MEM_AWID); end
   endtask

   task automatic test_write_incr;
      aw_delay = 2;
      for (int i = 0; i < 4; i++) wsrc[i] = 32'hA0 + 32'(i);
      clear_mon; wi = 0; wn = 4;
      issue(1, 4'd5, 32'h10, 8'd3, 3'd2, 2'b01);
      wait_done("write_incr");
      tests++;
      if (aw_hi !== 3 || aw_moved)
         begin fails++; $display("[TB] FAIL wr_awvalid_hold: %0d cycles moved=%0d, required 3 moved=0", aw_hi, aw_moved); end
      tests++;
      if ({aw_addr_q, aw_len_q, aw_id_q} !== {32'h10, 8'd3, 4'd5})
         begin fails++; $display("[TB] FAIL wr_aw_payload: %h/%h/%h required 10/03/5", aw_addr_q, aw_len_q, aw_id_q); end
      tests++;
      if (wq_data.size() != 4)
         begin fails++; $display("[TB] FAIL wr_beat_count: got %0d required 4", wq_data.size()); end
      for (int i = 0; i < 4 && i < wq_data.size(); i++) begin
         tests++;
         if (wq_data[i] !== 32'hA0 + 32'(i) || wq_last[i] !== (i == 3))
            begin fails++; $display("[TB] FAIL wr_beat%0d: data %h last %0d required %h last %0d",
               i, wq_data[i], wq_last[i], 32'hA0 + 32'(i), (i == 3)); end
      end
      tests++;
      if (done_cnt != 1 || done_w !== 1'b1 || done_r !== 2'b00 || done_i !== 4'd5)
         begin fails++; $display("[TB] FAIL wr_done: cnt %0d write %b resp %b id %0d required 1 1 00 5",
            done_cnt, done_w, done_r, done_i); end
   endtask

   task automatic test_read_incr;
      ar_delay = 1;
      clear_mon;
      issue(0, 4'd6, 32'h10, 8'd3, 3'd2, 2'b01);
      wait_done("read_incr");
      tests++;
      if (ar_hi !== 2)
         begin fails++; $display("[TB] FAIL rd_arvalid_hold: got %0d cycles required 2", ar_hi); end
      tests++;
      if (rq_data.size() != 4)
         begin fails++; $display("[TB] FAIL rd_beat_count: got %0d required 4", rq_data.size()); end
      for (int i = 0; i < 4 && i < rq_data.size(); i++) begin
         tests++;
         if (rq_data[i] !== 32'hA0 + 32'(i) || rq_last[i] !== (i == 3))
            begin fails++; $display("[TB] FAIL rd_beat%0d: data %h last %0d required %h last %0d",
               i, rq_data[i], rq_last[i], 32'hA0 + 32'(i), (i == 3)); end
      end
      tests++;
      if (done_cnt != 1 || done_w !== 1'b0 || done_r !== 2'b00 || done_i !== 4'd6)
         begin fails++; $display("[TB] FAIL rd_done: cnt %0d write %b resp %b id %0d required 1 0 00 6",
            done_cnt, done_w, done_r, done_i); end
   endtask

   task automatic test_back_to_back;
      aw_delay = 0; ar_delay = 0; wr_toggle = 1;
      for (int i = 0; i < 8; i++) wsrc[i] = 32'hB0 + 32'(i);
      clear_mon; wi = 0; wn = 8;
      issue(1, 4'd2, 32'h40, 8'd7, 3'd2, 2'b01);
      wait_done("write_len7");
      wr_toggle = 0;
      tests++;
      if (wq_data.size() != 8)
         begin fails++; $display("[TB] FAIL wr7_beat_count: got %0d required 8", wq_data.size()); end
      for (int i = 0; i < 8 && i < wq_data.size(); i++) begin
         tests++;
         if (wq_data[i] !== 32'hB0 + 32'(i) || wq_last[i] !== (i == 7))
            begin fails++; $display("[TB] FAIL wr7_beat%0d: data %h last %0d required %h last %0d",
               i, wq_data[i], wq_last[i], 32'hB0 + 32'(i), (i == 7)); end
      end
      clear_mon; rd_stall_en = 1;
      issue(0, 4'd2, 32'h40, 8'd7, 3'd2, 2'b01);
      wait_done("read_len7");
      rd_stall_en = 0;
      tests++;
      if ({ar_addr_q, ar_len_q, ar_id_q} !== {32'h40, 8'd7, 4'd2})
         begin fails++; $display("[TB] FAIL rd7_ar_payload: %h/%h/%h required 40/07/2", ar_addr_q, ar_len_q, ar_id_q); end
      tests++;
      if (rstall !== 3)
         begin fails++; $display("[TB] FAIL rd7_rready_stall: got %0d cycles required 3", rstall); end
      tests++;
      if (rq_data.size() != 8)
         begin fails++; $display("[TB] FAIL rd7_beat_count: got %0d required 8", rq_data.size()); end
      for (int i = 0; i < 8 && i < rq_data.size(); i++) begin
         tests++;
         if (rq_data[i] !== 32'hB0 + 32'(i) || rq_last[i] !== (i == 7))
            begin fails++; $display("[TB] FAIL rd7_beat%0d: data %h last %0d required %h last %0d",
               i, rq_data[i], rq_last[i], 32'hB0 + 32'(i), (i == 7)); end
      end
      tests++;
      if (done_cnt != 1 || done_r !== 2'b00)
         begin fails++; $display("[TB] FAIL rd7_done: cnt %0d resp %b required 1 00", done_cnt, done_r); end
   endtask

   task automatic test_error_resp;
      clear_mon;
      issue(0, 4'd9, 32'h400, 8'd0, 3'd2, 2'b01);
      wait_done("read_err");
      tests++;
      if (done_cnt != 1 || done_w !== 1'b0 || done_r !== 2'b11 || done_i !== 4'd9)
         begin fails++; $display("[TB] FAIL rd_err_done: cnt %0d write %b resp %b id %0d required 1 0 11 9",
            done_cnt, done_w, done_r, done_i); end
      wsrc[0] = 32'hDEAD_BEEF;
      clear_mon; wi = 0; wn = 1;
      issue(1, 4'd9, 32'h400, 8'd0, 3'd2, 2'b01);
      wait_done("write_err");
      tests++;
      if (wq_data.size() != 1 || wq_last[0] !== 1'b1)
         begin fails++; $display("[TB] FAIL wr_len0_wlast: beats %0d, required 1 beat with WLAST", wq_data.size()); end
      tests++;
      if (done_cnt != 1 || done_w !== 1'b1 || done_r !== 2'b11 || done_i !== 4'd9)
         begin fails++; $display("[TB] FAIL wr_err_done: cnt %0d write %b resp %b id %0d required 1 1 11 9",
            done_cnt, done_w, done_r, done_i); end
   endtask

   task automatic test_reject;
      clear_mon; wi = 0; wn = 0;
      issue(1, 4'd7, 32'h20, 8'd3, 3'd2, 2'b10);
      wait_done("reject_burst");
      tests++;
      if (aw_hi != 0 || ar_hi != 0 || wq_data.size() != 0)
         begin fails++; $display("[TB] FAIL rej_bus_quiet: aw %0d ar %0d w %0d required 0 0 0",
            aw_hi, ar_hi, wq_data.size()); end
      tests++;
      if (done_cyc - hs_cyc != 2)
         begin fails++; $display("[TB] FAIL rej_latency: got %0d cycles required 2", done_cyc - hs_cyc); end
      tests++;
      if (done_cnt != 1 || done_w !== 1'b1 || done_r !== 2'b10 || done_i !== 4'd7)
         begin fails++; $display("[TB] FAIL rej_done: cnt %0d write %b resp %b id %0d required 1 1 10 7",
            done_cnt, done_w, done_r, done_i); end
      clear_mon;
      issue(0, 4'd4, 32'h20, 8'd0, 3'd3, 2'b01);
      wait_done("reject_size");
      tests++;
      if (ar_hi != 0 || done_cnt != 1 || done_w !== 1'b0 || done_r !== 2'b10 || done_i !== 4'd4)
         begin fails++; $display("[TB] FAIL rej_size: ar %0d cnt %0d write %b resp %b id %0d required 0 1 0 10 4",
            ar_hi, done_cnt, done_w, done_r, done_i); end
   endtask

   task automatic test_reset_mid_burst;
      int n = 0;
      aw_delay = 0;
      for (int i = 0; i < 4; i++) wsrc[i] = 32'hC0 + 32'(i);
      clear_mon; wi = 0; wn = 4;
      issue(1, 4'd3, 32'h80, 8'd3, 3'd2, 2'b01);
      while (wq_data.size() == 0 && n < 50) begin @(posedge ACLK); n++; end
      #1 ARESET = 1;
      @(posedge ACLK);
      #1 ARESET = 0; wn = 0;
      @(negedge ACLK);
      tests++;
      if ({bus.MEM_WVALID, bus.MEM_AWVALID, bus.MEM_BREADY, bus.done} !== 4'b0)
         begin fails++; $display("[TB] FAIL rst_mid_outputs: wvalid/awvalid/bready/done %b required 0000",
            {bus.MEM_WVALID, bus.MEM_AWVALID, bus.MEM_BREADY, bus.done}); end
      @(posedge ACLK);
      @(negedge ACLK);
      tests++;
      if (bus.cmd_ready !== 1'b1 || done_cnt != 0)
         begin fails++; $display("[TB] FAIL rst_mid_idle: cmd_ready %b dones %0d required 1 0",
            bus.cmd_ready, done_cnt); end
      clear_mon;
      issue(0, 4'd1, 32'h10, 8'd0, 3'd2, 2'b01);
      wait_done("after_reset");
      tests++;
      if (rq_data.size() != 1 || rq_data[0] !== 32'hA0 || done_r !== 2'b00 || done_cnt != 1)
         begin fails++; $display("[TB] FAIL rst_recover: beats %0d data %h resp %b required 1 a0 00",
            rq_data.size(), rq_data[0], done_r); end
   endtask

   initial begin : watchdog
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin : main
      ARESET = 1;
      bus.cmd_valid = 0; bus.cmd_write = 0; bus.cmd_id = '0; bus.cmd_addr = '0;
      bus.cmd_len = '0; bus.cmd_size = '0; bus.cmd_burst = '0;
      test_reset;
      test_write_incr;
      test_read_incr;
      test_back_to_back;
      test_error_resp;
      test_reject;
      test_reset_mid_burst;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
